ifu_fetch: RTL and testbench
============================

// Module: ifu_fetch
// PURPOSE
//  Instruction fetch unit: transmitting end of the fetch->decode valid/ready link.
//  Issues one instruction-memory read per instruction and presents {instr, pc} to decode.
//  Holds until writeback signals retirement, then fetches from the resolved next PC.
//  Multi-cycle, one instruction in flight. Sits between instruction memory and decode.
// PARAMETERS
//  RESET_PC   32'h8000_0000  first fetch address after reset
//  TIMEOUT    16'd1024       max cycles waiting for a memory response; 0 = no timeout
//  TO_W       16             width of the timeout counter
// PORTS
//  clk            in   1   clock, rising edge
//  rst            in   1   synchronous, active-high reset
//  ifu_valid      out  1   {instr, pc} valid for decode
//  idu_ready      in   1   decode accepts this cycle
//  instr          out  32  fetched instruction
//  pc             out  32  address of instr
//  wbu_valid      in   1   current instruction retired; next_pc valid
//  next_pc        in   32  resolved next PC (pc+4, branch/jump target, mtvec, mepc)
//  imem_req_valid out  1   memory read request
//  imem_req_ready in   1   memory accepts request
//  imem_addr      out  32  read address (= pc)
//  imem_rsp_valid in   1   read data valid
//  imem_rsp_data  in   32  read data
//  imem_rsp_err   in   1   bus error on this response
//  ifu_fault      out  1   sticky fault: bus error, timeout, or misaligned next_pc
//  fetch_cnt      out  32  number of instructions accepted by decode
// BEHAVIOUR
//  FSM states: REQ, WAIT_RSP, VALID, WAIT_WB, FAULT.
//  Reset state: REQ, with pc=RESET_PC, instr=0, fetch_cnt=0, ifu_fault=0, timeout counter=0.
//  While rst=1: ifu_valid=0 and imem_req_valid=0.
//  REQ: imem_req_valid=1, imem_addr=pc.
//    - On imem_req_ready: go to WAIT_RSP and clear the timeout counter.
//  WAIT_RSP: the timeout counter increments every cycle.
//    - rsp_valid & !rsp_err: instr<=rsp_data, go to VALID.
//    - rsp_valid & rsp_err: go to FAULT.
//    - TIMEOUT!=0 and counter==TIMEOUT-1 with no response: go to FAULT.
//    - Response wins over timeout in the same cycle.
//    - rsp_valid in any other state is ignored.
//  VALID: ifu_valid=1; instr and pc are held stable until the handshake.
//    - On idu_ready: fetch_cnt++ (wraps at 2^32), go to WAIT_WB; ifu_valid=0 next cycle.
//    - Handshake latency is 1 cycle minimum.
//  WAIT_WB: ifu_valid=0.
//    - On wbu_valid: if next_pc[1:0]!=0, go to FAULT and hold pc.
//    - Otherwise pc<=next_pc and go to REQ.
//    - wbu_valid outside WAIT_WB is ignored.
//  FAULT: terminal until reset.
//    - ifu_fault=1, ifu_valid=0, imem_req_valid=0; instr and pc frozen.
//  Fetch-to-valid latency with zero-wait memory: REQ(1) + WAIT_RSP(1) -> VALID on cycle 3.
//  Reset mid-operation (any state): return to REQ at RESET_PC next cycle.
//    - An outstanding memory response after reset is discarded; it arrives in REQ, not WAIT_RSP.
//  imem_addr and pc change only on WAIT_WB->REQ or reset.
//  Request is never withdrawn before req_ready.
// TESTING
//  1 Reset, zero-wait memory returning 32'h00000013 -> req at 0x8000_0000;
//    ifu_valid=1 on cycle 3; instr=0x13; pc=0x8000_0000.
//  2 idu_ready held 0 for 5 cycles in VALID -> ifu_valid stays 1, instr/pc stable;
//    ready=1 -> fetch_cnt=1.
//  3 wbu_valid with next_pc=0x8000_0010 -> next req addr 0x8000_0010;
//    wbu_valid pulsed in VALID -> no effect.
//  4 Response with rsp_err=1 -> ifu_fault=1 next cycle and sticky;
//    no further requests until rst.
//  5 TIMEOUT=4, memory silent -> ifu_fault=1 after exactly 4 WAIT_RSP cycles;
//    next_pc=0x8000_0002 -> fault.
//  6 rst asserted in WAIT_RSP, stale rsp_valid next cycle -> ignored;
//    fetch restarts at RESET_PC, fetch_cnt=0.

Source files
------------

// File: rtl/ifu_fetch_if.sv
// Fetch-unit link bundle: instruction-memory read channel, fetch->decode
// handshake, writeback redirect, and fault/progress status.
interface ifu_fetch_if;
  logic        ifu_valid;
  logic        idu_ready;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        wbu_valid;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        ifu_fault;
  logic [31:0] fetch_cnt;

  modport master (
    output ifu_valid, instr, pc, imem_req_valid, imem_addr, ifu_fault, fetch_cnt,
    input  idu_ready, wbu_valid, next_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, imem_rsp_err
  );

  modport slave (
    input  ifu_valid, instr, pc, imem_req_valid, imem_addr, ifu_fault, fetch_cnt,
    output idu_ready, wbu_valid, next_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, imem_rsp_err
  );
endinterface

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one memory read per instruction, one instruction in
// flight, presents {instr, pc} to decode and waits for retirement before refetch.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int          TO_W     = 16,
  parameter logic [15:0] TIMEOUT  = 16'd1024
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);

  typedef enum logic [2:0] {
    S_REQ      = 3'd0,
    S_WAIT_RSP = 3'd1,
    S_VALID    = 3'd2,
    S_WAIT_WB  = 3'd3,
    S_FAULT    = 3'd4
  } state_t;

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(32'(TIMEOUT) - 32'd1);
  localparam logic            TO_EN   = (TIMEOUT != 16'd0);

  function automatic logic misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  state_t          state_r;
  logic [31:0]     pc_r;
  logic [31:0]     instr_r;
  logic [31:0]     fetch_cnt_r;
  logic [TO_W-1:0] to_cnt_r;
  logic            req_valid_r;
  logic            valid_r;
  logic            fault_r;

  // Fetch FSM; handshake outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_REQ;
      pc_r        <= RESET_PC;
      instr_r     <= 32'h0000_0000;
      fetch_cnt_r <= 32'h0000_0000;
      to_cnt_r    <= {TO_W{1'b0}};
      req_valid_r <= 1'b1;
      valid_r     <= 1'b0;
      fault_r     <= 1'b0;
    end else begin
      case (state_r)
        S_REQ: begin
          if (bus.imem_req_ready) begin
            state_r     <= S_WAIT_RSP;
            to_cnt_r    <= {TO_W{1'b0}};
            req_valid_r <= 1'b0;
          end else begin
            req_valid_r <= 1'b1;
          end
        end
        S_WAIT_RSP: begin
          to_cnt_r <= to_cnt_r + TO_W'(32'd1);
          // A response in the timeout cycle still counts as a good fetch.
          if (bus.imem_rsp_valid && !bus.imem_rsp_err) begin
            instr_r <= bus.imem_rsp_data;
            state_r <= S_VALID;
            valid_r <= 1'b1;
          end else if (bus.imem_rsp_valid || (TO_EN && (to_cnt_r == TO_LAST))) begin
            state_r <= S_FAULT;
            fault_r <= 1'b1;
          end else begin
            state_r <= S_WAIT_RSP;
          end
        end
        S_VALID: begin
          if (bus.idu_ready) begin
            fetch_cnt_r <= fetch_cnt_r + 32'd1;
            state_r     <= S_WAIT_WB;
            valid_r     <= 1'b0;
          end else begin
            valid_r <= 1'b1;
          end
        end
        S_WAIT_WB: begin
          if (bus.wbu_valid) begin
            if (misaligned(bus.next_pc)) begin
              state_r <= S_FAULT;
              fault_r <= 1'b1;
            end else begin
              pc_r        <= bus.next_pc;
              state_r     <= S_REQ;
              req_valid_r <= 1'b1;
            end
          end else begin
            state_r <= S_WAIT_WB;
          end
        end
        S_FAULT: begin
          state_r     <= S_FAULT;
          fault_r     <= 1'b1;
          req_valid_r <= 1'b0;
          valid_r     <= 1'b0;
        end
        default: begin
          // Unreachable encoding: park in the safe terminal state.
          state_r     <= S_FAULT;
          fault_r     <= 1'b1;
          req_valid_r <= 1'b0;
          valid_r     <= 1'b0;
        end
      endcase
    end
  end

  // Reset gating keeps both valids low for the whole reset window, including before the first edge.
  assign bus.imem_req_valid = req_valid_r & ~rst;
  assign bus.ifu_valid      = valid_r & ~rst;
  assign bus.imem_addr      = pc_r;
  assign bus.pc             = pc_r;
  assign bus.instr          = instr_r;
  assign bus.ifu_fault      = fault_r;
  assign bus.fetch_cnt      = fetch_cnt_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: cycle table, directed corner sequences,
// and a randomized transaction-level scoreboard run.
module tb_ifu_fetch;
  localparam logic [31:0] A = 32'h8000_0000;
  localparam logic [31:0] B = 32'h8000_0010;

  typedef struct {
    logic rst, req_ready, rsp_valid;
    logic [31:0] rsp_data;
    logic rsp_err, idu_ready, wbu_valid;
    logic [31:0] next_pc;
  } in_t;

  typedef struct {
    in_t i;
    logic chk, ifu_valid, req_valid, fault;
    logic [31:0] addr, instr, pc, cnt;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;

  ifu_fetch_if bus();
  ifu_fetch #(.RESET_PC(A), .TO_W(16), .TIMEOUT(16'd4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic in_t mk(input logic r, rr, rv, input logic [31:0] rd,
                             input logic re, ir, wv, input logic [31:0] np);
    in_t x;
    x.rst = r; x.req_ready = rr; x.rsp_valid = rv; x.rsp_data = rd;
    x.rsp_err = re; x.idu_ready = ir; x.wbu_valid = wv; x.next_pc = np;
    return x;
  endfunction

  function automatic in_t idle();
    return mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
  endfunction

  task automatic apply(input in_t x);
    @(posedge clk); #1;
    rst = x.rst;
    bus.imem_req_ready = x.req_ready;
    bus.imem_rsp_valid = x.rsp_valid;
    bus.imem_rsp_data  = x.rsp_data;
    bus.imem_rsp_err   = x.rsp_err;
    bus.idu_ready      = x.idu_ready;
    bus.wbu_valid      = x.wbu_valid;
    bus.next_pc        = x.next_pc;
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check1({tag, ".ifu_valid"}, bus.ifu_valid, v.ifu_valid);
    check1({tag, ".req_valid"}, bus.imem_req_valid, v.req_valid);
    check1({tag, ".fault"}, bus.ifu_fault, v.fault);
    check({tag, ".addr"}, bus.imem_addr, v.addr);
    check({tag, ".instr"}, bus.instr, v.instr);
    check({tag, ".pc"}, bus.pc, v.pc);
    check({tag, ".fetch_cnt"}, bus.fetch_cnt, v.cnt);
  endtask

  task automatic do_reset();
    apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
  endtask

  vec_t tbl[16];

  initial begin
    in_t hs, rq;
    logic [31:0] exp_pc, exp_cnt, data, np;
    int s, d, h, w;

    rst = 1'b1;
    bus.imem_req_ready = 1'b0; bus.imem_rsp_valid = 1'b0; bus.imem_rsp_data = 32'h0;
    bus.imem_rsp_err = 1'b0; bus.idu_ready = 1'b0; bus.wbu_valid = 1'b0; bus.next_pc = 32'h0;
    hs = mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0);
    rq = mk(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    // Reset, first fetch, decode stall, ignored pulses, redirect, request hold.
    tbl[0]  = '{mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0), 1'b0, 1'b0, 1'b0, 1'b0, A, 32'h0, A, 32'd0};
    tbl[1]  = '{mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, A, 32'h0, A, 32'd0};
    tbl[2]  = '{rq, 1'b1, 1'b0, 1'b1, 1'b0, A, 32'h0, A, 32'd0};
    tbl[3]  = '{mk(1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0), 1'b1, 1'b0, 1'b0, 1'b0, A, 32'h0, A, 32'd0};
    tbl[4]  = '{mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0020), 1'b1, 1'b1, 1'b0, 1'b0, A, 32'h13, A, 32'd0};
    tbl[5]  = '{mk(1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 32'h0), 1'b1, 1'b1, 1'b0, 1'b0, A, 32'h13, A, 32'd0};
    tbl[6]  = '{idle(), 1'b1, 1'b1, 1'b0, 1'b0, A, 32'h13, A, 32'd0};
    tbl[7]  = '{idle(), 1'b1, 1'b1, 1'b0, 1'b0, A, 32'h13, A, 32'd0};
    tbl[8]  = '{idle(), 1'b1, 1'b1, 1'b0, 1'b0, A, 32'h13, A, 32'd0};
    tbl[9]  = '{hs, 1'b1, 1'b1, 1'b0, 1'b0, A, 32'h13, A, 32'd0};
    tbl[10] = '{idle(), 1'b1, 1'b0, 1'b0, 1'b0, A, 32'h13, A, 32'd1};
    tbl[11] = '{mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, B), 1'b1, 1'b0, 1'b0, 1'b0, A, 32'h13, A, 32'd1};
    tbl[12] = '{idle(), 1'b1, 1'b0, 1'b1, 1'b0, B, 32'h13, B, 32'd1};
    tbl[13] = '{idle(), 1'b1, 1'b0, 1'b1, 1'b0, B, 32'h13, B, 32'd1};
    tbl[14] = '{rq, 1'b1, 1'b0, 1'b1, 1'b0, B, 32'h13, B, 32'd1};
    tbl[15] = '{idle(), 1'b1, 1'b0, 1'b0, 1'b0, B, 32'h13, B, 32'd1};

    for (int i = 0; i < 16; i++) begin
      apply(tbl[i].i);
      if (tbl[i].chk) check_vec($sformatf("tbl[%0d]", i), tbl[i]);
    end

    // Bus error: fault next cycle, sticky, no more requests.
    do_reset();
    apply(rq);
    apply(mk(1'b0, 1'b0, 1'b1, 32'h1234, 1'b1, 1'b0, 1'b0, 32'h0));
    apply(rq);
    check1("err.fault", bus.ifu_fault, 1'b1);
    check("err.instr", bus.instr, 32'h0);
    for (int k = 0; k < 4; k++) begin
      apply(mk(1'b0, 1'b1, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 32'h8000_0040));
      check1("err.sticky", bus.ifu_fault, 1'b1);
      check1("err.no_req", bus.imem_req_valid, 1'b0);
      check1("err.no_valid", bus.ifu_valid, 1'b0);
      check("err.pc", bus.pc, A);
    end

    // Timeout after exactly four silent response cycles.
    do_reset();
    apply(rq);
    for (int k = 1; k <= 4; k++) begin
      apply(idle());
      check1($sformatf("to.wait%0d.fault", k), bus.ifu_fault, 1'b0);
    end
    apply(idle());
    check1("to.fault", bus.ifu_fault, 1'b1);
    check1("to.no_req", bus.imem_req_valid, 1'b0);

    // Response in the last allowed cycle wins; then misaligned redirect faults.
    do_reset();
    apply(rq);
    for (int k = 1; k <= 3; k++) apply(idle());
    apply(mk(1'b0, 1'b0, 1'b1, 32'h67, 1'b0, 1'b0, 1'b0, 32'h0));
    apply(idle());
    check1("late.fault", bus.ifu_fault, 1'b0);
    check1("late.valid", bus.ifu_valid, 1'b1);
    check("late.instr", bus.instr, 32'h67);
    apply(hs);
    apply(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0002));
    apply(idle());
    check1("mis.fault", bus.ifu_fault, 1'b1);
    check("mis.pc", bus.pc, A);
    check1("mis.no_req", bus.imem_req_valid, 1'b0);

    // Reset while waiting for a response; the stale response must be dropped.
    do_reset();
    apply(rq);
    apply(mk(1'b0, 1'b0, 1'b1, 32'h13, 1'b0, 1'b0, 1'b0, 32'h0));
    apply(hs);
    apply(mk(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 32'h8000_0100));
    apply(rq);
    check("rst.addr_before", bus.imem_addr, 32'h8000_0100);
    apply(mk(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
    check1("rst.req_low", bus.imem_req_valid, 1'b0);
    apply(mk(1'b0, 1'b0, 1'b1, 32'h0BAD_0BAD, 1'b0, 1'b0, 1'b0, 32'h0));
    check1("rst.req", bus.imem_req_valid, 1'b1);
    check("rst.addr", bus.imem_addr, A);
    check("rst.cnt", bus.fetch_cnt, 32'd0);
    apply(idle());
    check1("rst.stale_valid", bus.ifu_valid, 1'b0);
    check1("rst.still_req", bus.imem_req_valid, 1'b1);
    check("rst.stale_instr", bus.instr, 32'h0);
    apply(rq);
    apply(mk(1'b0, 1'b0, 1'b1, 32'h33, 1'b0, 1'b0, 1'b0, 32'h0));
    apply(idle());
    check1("rst.refetch_valid", bus.ifu_valid, 1'b1);
    check("rst.refetch_instr", bus.instr, 32'h33);

    // Randomized transactions against a per-instruction scoreboard.
    do_reset();
    exp_pc = A;
    exp_cnt = 32'd0;
    for (int n = 0; n < 150; n++) begin
      s = int'($urandom_range(0, 3));
      for (int k = 0; k <= s; k++) begin
        apply(mk(1'b0, (k == s), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0));
        check1("rnd.req_valid", bus.imem_req_valid, 1'b1);
        check("rnd.addr", bus.imem_addr, exp_pc);
        check1("rnd.req_ifu_valid", bus.ifu_valid, 1'b0);
      end
      d = int'($urandom_range(0, 3));
      data = $urandom;
      for (int k = 0; k <= d; k++) begin
        apply(mk(1'b0, 1'b0, (k == d), data, 1'b0, 1'b0, 1'b0, 32'h0));
        check1("rnd.wait_req", bus.imem_req_valid, 1'b0);
        check1("rnd.wait_valid", bus.ifu_valid, 1'b0);
        check1("rnd.wait_fault", bus.ifu_fault, 1'b0);
      end
      h = int'($urandom_range(0, 4));
      for (int k = 0; k <= h; k++) begin
        apply(mk(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                 (k == h), 1'($urandom_range(0, 1)), $urandom));
        check1("rnd.valid", bus.ifu_valid, 1'b1);
        check("rnd.instr", bus.instr, data);
        check("rnd.pc", bus.pc, exp_pc);
        check("rnd.cnt_hold", bus.fetch_cnt, exp_cnt);
      end
      exp_cnt = exp_cnt + 32'd1;
      w = int'($urandom_range(0, 3));
      np = $urandom & 32'hFFFF_FFFC;
      for (int k = 0; k <= w; k++) begin
        apply(mk(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom, 1'b0, 1'b0, (k == w), np));
        check1("rnd.wb_valid", bus.ifu_valid, 1'b0);
        check1("rnd.wb_req", bus.imem_req_valid, 1'b0);
        check("rnd.cnt", bus.fetch_cnt, exp_cnt);
      end
      exp_pc = np;
    end
    check1("rnd.final_fault", bus.ifu_fault, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
